// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and a one-bit-per-cycle serial shifter.
// Single-cycle ops complete in one edge; shifts by n take n edges after the accept.
module alu_exec_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy,
   output logic [1:0]      o_dbg_state
);

   // Handshake: a transfer happens on any rising edge where valid && ready.
   // in_ready depends only on state and out_ready, never on in_valid.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_work;
   logic [SHW-1:0]    r_cnt;
   logic [1:0]        r_op;
   logic [XLEN-1:0]   r_result;
   logic              r_zero;

   logic              w_accept;
   logic              w_is_shift;
   logic [SHW-1:0]    w_shamt;
   logic [XLEN-1:0]   w_alu;
   logic [XLEN-1:0]   w_step;

   assign in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_shamt     = op_b[SHW-1:0];
   assign w_is_shift  = (alu_control == 4'd5) || (alu_control == 4'd6) || (alu_control == 4'd7);
   assign out_valid   = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign result      = r_result;
   assign zero        = r_zero;
   assign o_dbg_state = r_state;

   // Shift codes only reach this path with amount 0, so they pass op_a through.
   always_comb begin
      w_alu = '0;
      case (alu_control)
         4'd0:    w_alu = op_a + op_b;
         4'd1:    w_alu = op_a - op_b;
         4'd2:    w_alu = op_a ^ op_b;
         4'd3:    w_alu = op_a | op_b;
         4'd4:    w_alu = op_a & op_b;
         4'd5:    w_alu = op_a;
         4'd6:    w_alu = op_a;
         4'd7:    w_alu = op_a;
         4'd8:    w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'd9:    w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         4'd10:   w_alu = op_a - op_b;
         default: w_alu = '0;
      endcase
   end

   // r_op holds alu_control[1:0]: 01 SLL, 10 SRL, 11 SRA.
   always_comb begin
      w_step = r_work;
      case (r_op)
         2'b01:   w_step = {r_work[XLEN-2:0], 1'b0};
         2'b10:   w_step = {1'b0, r_work[XLEN-1:1]};
         2'b11:   w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
         default: w_step = r_work;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_work   <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_work  <= op_a;
                     r_cnt   <= w_shamt;
                     r_op    <= alu_control[1:0];
                     r_state <= S_SHIFT;
                  end else begin
                     r_result <= w_alu;
                     r_zero   <= (w_alu == '0);
                     r_state  <= S_DONE;
                  end
               end else if ((r_state == S_DONE) && out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_work <= w_step;
               r_cnt  <= r_cnt - SHW'(1);
               if (r_cnt == SHW'(1)) begin
                  r_result <= w_step;
                  r_zero   <= (w_step == '0);
                  r_state  <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
